// File: rtl/fifo_wptr_gray.sv
// rtl/fifo_wptr_gray.sv - write-side binary/Gray pointer, read-pointer synchronizer and full flag
// Almost-full flag and write-side level are built only when ALMOST_FULL_EN is defined.
module fifo_wptr_gray #(
    parameter int DEPTH_SIZE = 4,
    parameter int AF_THRESH  = (1 << DEPTH_SIZE) - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DEPTH_SIZE:0]   rd_gray_async,
    output logic [DEPTH_SIZE-1:0] wr_addr,
    output logic [DEPTH_SIZE:0]   wr_gray,
    output logic                  full,
    output logic                  wr_ovf,
    output logic                  almost_full,
    output logic [DEPTH_SIZE:0]   wr_level
);
    localparam int D = DEPTH_SIZE;

    if (DEPTH_SIZE < 2) begin : g_bad_depth
        $error("fifo_wptr_gray: DEPTH_SIZE must be at least 2");
    end
    if ((AF_THRESH < 0) || (AF_THRESH > (1 << DEPTH_SIZE))) begin : g_bad_thresh
        $error("fifo_wptr_gray: AF_THRESH out of range");
    end

    logic [D:0] wr_bin;
    logic [D:0] rd_s1;
    logic [D:0] rd_s2;
    logic [D:0] bin_next;
    logic [D:0] gray_next;
    logic [D:0] full_gray;
    logic       wr_fire;

    assign wr_fire   = wr_en & ~full;
    assign bin_next  = wr_bin + {{D{1'b0}}, wr_fire};
    assign gray_next = bin_next ^ (bin_next >> 1);
    // The write pointer is a full lap ahead when only its top two Gray bits differ.
    assign full_gray = {~rd_s2[D:D-1], rd_s2[D-2:0]};
    assign wr_addr   = wr_bin[D-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1 <= '0;
            rd_s2 <= '0;
        end else begin
            rd_s1 <= rd_gray_async;
            rd_s2 <= rd_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin  <= '0;
            wr_gray <= '0;
            full    <= 1'b0;
            wr_ovf  <= 1'b0;
        end else begin
            wr_bin  <= bin_next;
            wr_gray <= gray_next;
            full    <= (gray_next == full_gray);
            wr_ovf  <= wr_en & full;
        end
    end

`ifdef ALMOST_FULL_EN
    localparam logic [D:0] AF_LIMIT = (D + 1)'(AF_THRESH);

    logic [D:0] rd_bin;
    logic [D:0] level_next;

    // Each binary bit is the XOR of the Gray bits at and above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= D; i++) begin
            rd_bin[i] = ^(rd_s2 >> i);
        end
    end

    assign level_next = bin_next - rd_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_level    <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_level    <= level_next;
            almost_full <= (level_next >= AF_LIMIT);
        end
    end
`else
    assign wr_level    = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_gray.sv
// tb/tb_fifo_wptr_gray.sv - self-checking bench for fifo_wptr_gray against an occupancy-count model
module tb_fifo_wptr_gray;
    localparam int D     = 4;
    localparam int DEPTH = 16;
`ifdef ALMOST_FULL_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [D:0]   rd_gray_async;
    logic [D-1:0] wr_addr;
    logic [D:0]   wr_gray;
    logic         full;
    logic         wr_ovf;
    logic         almost_full;
    logic [D:0]   wr_level;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Model state: unbounded write/read counts plus two-edge history of the driven read count.
    int  m_wr, rd_cnt, rd_h1, rd_h2, m_level;
    bit  m_full, m_ovf, m_af;
    logic [D:0] prev_gray;
    logic [D:0] last_gray;
    bit  saw_wrap;

    always #5 clk = ~clk;

    fifo_wptr_gray dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .rd_gray_async (rd_gray_async),
        .wr_addr       (wr_addr),
        .wr_gray       (wr_gray),
        .full          (full),
        .wr_ovf        (wr_ovf),
        .almost_full   (almost_full),
        .wr_level      (wr_level)
    );

    function automatic logic [D:0] gray_of(input int v);
        logic [31:0] t;
        logic [D:0]  b;
        t = v;
        b = t[D:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr      = 0;
        rd_cnt    = 0;
        rd_h1     = 0;
        rd_h2     = 0;
        m_full    = 1'b0;
        m_ovf     = 1'b0;
        m_level   = 0;
        m_af      = 1'b0;
        prev_gray = '0;
    endtask

    task automatic drive_rd();
        rd_gray_async = gray_of(rd_cnt);
    endtask

    task automatic check_zero_outputs(input string phase);
        check({phase, "_addr"},  wr_addr, 0);
        check({phase, "_gray"},  wr_gray, 0);
        check({phase, "_full"},  full, 0);
        check({phase, "_ovf"},   wr_ovf, 0);
        check({phase, "_af"},    almost_full, 0);
        check({phase, "_level"}, wr_level, 0);
    endtask

    task automatic tick();
        int diff;
        @(posedge clk);
        m_ovf = wr_en && m_full;
        if (wr_en && !m_full) m_wr++;
        diff    = m_wr - rd_h2;
        m_full  = (diff == DEPTH);
        m_af    = AF_ON && (diff >= 14);
        m_level = AF_ON ? diff : 0;
        rd_h2   = rd_h1;
        rd_h1   = rd_cnt;
        #1;
        check("wr_addr",     wr_addr, m_wr % DEPTH);
        check("wr_gray",     wr_gray, gray_of(m_wr));
        check("full",        full, m_full);
        check("wr_ovf",      wr_ovf, m_ovf);
        check("wr_level",    wr_level, m_level);
        check("almost_full", almost_full, m_af);
        check("gray_step",   $countones(wr_gray ^ prev_gray) <= 1, 1);
        prev_gray = wr_gray;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        model_reset();
        drive_rd();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Fill from empty
        wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check("full_at_15", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_gray", wr_gray, 5'b11000);
        check("fill_addr", wr_addr, 0);

        // Overflow while full
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_pulse", wr_ovf, 1);
            check("ovf_gray", wr_gray, 5'b11000);
        end

        // Read release, visible at the third edge
        wr_en  = 1'b0;
        rd_cnt = 1;
        drive_rd();
        tick();
        tick();
        check("full_held", full, 1);
        tick();
        check("full_drop", full, 0);
        wr_en = 1'b1;
        tick();
        check("release_gray", wr_gray, 5'b11001);

        // Wrap through 31 -> 0 with matched reads
        saw_wrap = 1'b0;
        for (int i = 0; i < 80 && m_wr < 36; i++) begin
            last_gray = wr_gray;
            tick();
            if (last_gray == 5'b10000 && wr_gray == 5'b00000) saw_wrap = 1'b1;
            if (rd_cnt < m_wr) rd_cnt++;
            drive_rd();
        end
        check("wrap_seen", saw_wrap, 1);

        // Randomized traffic: slow reads, then fast reads
        for (int i = 0; i < 400; i++) begin
            wr_en = ($urandom_range(0, 3) != 0);
            if (rd_cnt < m_wr) begin
                if (i < 200) begin
                    if ($urandom_range(0, 2) == 0) rd_cnt++;
                end else begin
                    if ($urandom_range(0, 3) != 0) rd_cnt++;
                end
            end
            drive_rd();
            tick();
        end

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        wr_en = 1'b0;
        model_reset();
        drive_rd();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wr_en = 1'b1;
        repeat (4) tick();
        check("pre_reset_gray", wr_gray, 5'b00110);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        drive_rd();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_reset_gray", wr_gray, 5'b00001);

        // Almost-full threshold and level
        rst_n = 1'b0;
        wr_en = 1'b0;
        model_reset();
        drive_rd();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wr_en = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 13) check("af_at_13", almost_full, 0);
        end
        check("af_level14", wr_level, AF_ON ? 14 : 0);
        check("af_set", almost_full, AF_ON);
        wr_en  = 1'b0;
        rd_cnt = 4;
        drive_rd();
        tick();
        tick();
        check("af_level_held", wr_level, AF_ON ? 14 : 0);
        tick();
        check("af_level10", wr_level, AF_ON ? 10 : 0);
        check("af_clear", almost_full, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_gray.md
# fifo_wptr_gray

Write-side pointer and flag generator for the asynchronous ping-pong FIFO. Keeps the binary write pointer, encodes it to a registered Gray pointer for export to the read clock domain, and synchronizes the incoming Gray read pointer. It compares the two pointers to produce a registered `full` flag. It is the encoding counterpart of the read-side Gray-to-binary decode path and sits between the write-port logic and the dual-port RAM address input.

## Interface
- `DEPTH_SIZE`, default 4: address width. FIFO depth is 2^DEPTH_SIZE. Pointers are DEPTH_SIZE+1 bits wide. Legal range is DEPTH_SIZE ≥ 2.
- `AF_THRESH`, default 2^DEPTH_SIZE − 2: almost-full threshold in entries. Used only when `ALMOST_FULL_EN` is defined.

- `clk` input 1: write-domain clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write request from the write port.
- `rd_gray_async` input DEPTH_SIZE+1: Gray read pointer from the read domain. It is asynchronous to `clk`.
- `wr_addr` output DEPTH_SIZE: RAM write address, equal to `wr_bin[DEPTH_SIZE-1:0]`.
- `wr_gray` output DEPTH_SIZE+1: registered Gray write pointer, for export to the read domain.
- `full` output 1: registered full flag.
- `wr_ovf` output 1: one-cycle pulse for a write attempted while full.
- `almost_full` output 1: registered flag, `wr_level` ≥ AF_THRESH.
- `wr_level` output DEPTH_SIZE+1: registered occupancy as seen from the write side.

## Operation
- **Reset state:**
  - All registers are 0: `wr_bin`, `wr_gray`, the sync stages `rd_s1` and `rd_s2`, `full`, `wr_ovf`, `almost_full`, `wr_level`.
  - `wr_addr` is 0.
  - Reset acts immediately on `rst_n` falling, including mid-operation, and takes priority over everything.
- **Synchronizer:**
  - Two-flop chain: `rd_s1 <= rd_gray_async`, then `rd_s2 <= rd_s1`.
  - No logic between the two stages.
  - `rd_gray_async` is only ever sampled through this chain.
- **Write acceptance:** `wr_fire = wr_en & ~full`.
- **Next pointer:**
  - `bin_next = wr_bin + wr_fire`, computed modulo 2^(DEPTH_SIZE+1). It wraps from all-ones to 0.
  - `gray_next = bin_next ^ (bin_next >> 1)`.
  - Every clock, `wr_bin <= bin_next` and `wr_gray <= gray_next`.
  - `wr_gray` changes in at most one bit per cycle, and never glitches because it comes straight from a register.
- **Full flag:**
  - `full <= (gray_next == {~rd_s2[D:D-1], rd_s2[D-2:0]})`, where D = DEPTH_SIZE.
  - Computing from `gray_next` makes `full` assert on the same edge as the write that fills the last entry.
- **Overflow:**
  - `wr_ovf <= wr_en & full`.
  - An overflowing write does not change the pointer and does not touch the RAM address.
- **Simultaneous events:**
  - A write and a read-pointer advance can arrive in the same cycle. `full` uses the new `gray_next` and the current `rd_s2`.
  - Because the read pointer is seen late, `full` is conservative (pessimistic); that is intended.

## Timing
- Write latency: `wr_en` accepted at edge N gives `wr_addr` and `wr_gray` updated after edge N.
- The RAM write at edge N uses the pre-edge `wr_addr`.
- `full` reaches its value at the same edge N as the filling write.
- Read-pointer latency:
  - A change on `rd_gray_async` reaches `rd_s1` at edge 1 and `rd_s2` at edge 2.
  - It is reflected in `full`, `almost_full` and `wr_level` at edge 3.
- `wr_ovf`: high for exactly the one cycle after each edge that samples `wr_en & full`.

## Configuration
- **`ALMOST_FULL_EN` defined:**
  - `rd_bin` is the Gray-to-binary decode of `rd_s2`: MSB copied, each lower bit = the bit above XOR the Gray bit.
  - `wr_level <= bin_next - rd_bin`, computed modulo 2^(DEPTH_SIZE+1), giving a range of 0..2^DEPTH_SIZE.
  - `almost_full <= (bin_next - rd_bin) >= AF_THRESH`.
- **`ALMOST_FULL_EN` undefined:**
  - `almost_full` and `wr_level` are tied to constant 0.
  - No decode or subtract logic is built.
  - All other behaviour is identical.

## Test plan
- **Fill from reset:** DEPTH_SIZE=4, `rd_gray_async`=0, `wr_en`=1 for 16 cycles.
  - `full` goes to 1 on the 16th accepting edge.
  - Then `wr_gray`=5'b11000 and `wr_addr`=0.
- **Overflow:** while full, hold `wr_en`=1 for 3 cycles.
  - `wr_ovf` is high for 3 cycles.
  - `wr_gray` stays 5'b11000.
- **Read release:** from full, set `rd_gray_async`=5'b00001.
  - `full` drops at the 3rd edge after the change.
  - The next write then advances `wr_gray` to 5'b11001.
- **Wrap:** drive `wr_bin` through 31 to 0 using matched read-pointer advances.
  - `wr_gray` goes 5'b10000 → 5'b00000, one bit changing per step.
  - `full` is never falsely asserted.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously while `wr_en`=1 and `wr_gray`=5'b00110.
  - All outputs go to 0 without waiting for a clock edge.
  - The first write after reset release gives `wr_gray`=5'b00001.
- **`ALMOST_FULL_EN`:** AF_THRESH=14, 14 writes with the read pointer held at 0.
  - `almost_full`=1 and `wr_level`=14 on the 14th edge.
  - After `rd_gray_async` moves to gray(4)=5'b00110, `wr_level`=10 and `almost_full`=0 at edge 3.
